// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch FSM.
// Issues one read per instruction, waits for the memory response, holds the
// instruction for the decoder until it retires, then advances the PC.
// Optional feature: define FETCH_MISALIGN_CHK_EN to halt on a misaligned taken
// target (sticky misalign flag). Without it, targets are forced word-aligned.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        misalign
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_VALID = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        req_q, req_d;
  logic        vld_q, vld_d;
  logic        misalign_q, misalign_d;
  logic [31:0] pc_plus4;

  // Wraps modulo 2^32 naturally through the 32-bit adder.
  assign pc_plus4 = pc_q + 32'd4;

`ifndef FETCH_MISALIGN_CHK_EN
  // Low target bits are discarded when the target is forced word-aligned.
  logic unused_tgt_lo;
  assign unused_tgt_lo = |PCTarget[1:0];
`endif

  // Next-state, next-PC and capture logic for the fetch sequence.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    misalign_d = misalign_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ:  state_d = S_WAIT;
      S_WAIT: begin
        // Response only accepted here; stray rvalid elsewhere is ignored.
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        // PCSrc/PCTarget only matter in the retire cycle.
        if (instr_ready) begin
          state_d = S_REQ;
          if (PCSrc) begin
`ifdef FETCH_MISALIGN_CHK_EN
            if (PCTarget[1:0] != 2'b00) begin
              misalign_d = 1'b1;
              state_d    = S_HALT;
            end else begin
              pc_d = PCTarget;
            end
`else
            pc_d = {PCTarget[31:2], 2'b00};
`endif
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    // Handshake outputs are registered copies of the next state decode.
    req_d = (state_d == S_REQ);
    vld_d = (state_d == S_VALID);
  end

  // State and output registers; reset abandons any outstanding read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= NOP;
      req_q      <= 1'b0;
      vld_q      <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      req_q      <= req_d;
      vld_q      <= vld_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = vld_q;
  assign instr       = instr_q;
  assign PC          = pc_q;
  assign PCPlus4     = pc_plus4;
  assign misalign    = misalign_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset_n, input, 1; one clock, and reset is asynchronous and active-low.
REQ-004 The module SHALL have port PCSrc, input, 1, meaning take the branch/jump target (from the controller).
REQ-005 The module SHALL have port PCTarget, input, 32, meaning the branch/jump target address from the datapath.
REQ-006 The module SHALL have port imem_req, output, 1, meaning an instruction-memory read request.
REQ-007 The module SHALL have port imem_addr, output, 32, meaning the read address (equals PC).
REQ-008 The module SHALL have port imem_rvalid, input, 1, meaning read data is valid this cycle.
REQ-009 The module SHALL have port imem_rdata, input, 32, meaning the read data word.
REQ-010 The module SHALL have port instr_valid, output, 1, meaning instr is held for the decoder.
REQ-011 The module SHALL have port instr_ready, input, 1, meaning the current instruction retires this cycle.
REQ-012 The module SHALL have port instr, output, 32, meaning the fetched instruction; op, funct3 and funct7b5 derive from it.
REQ-013 The module SHALL have port PC, output, 32, meaning the address of instr.
REQ-014 The module SHALL have port PCPlus4, output, 32, meaning PC+4 modulo 2^32, combinational.
REQ-015 The module SHALL have port misalign, output, 1, meaning a sticky misaligned-target flag (see Configuration).

Function
REQ-016 The FSM SHALL have states IDLE, REQ, WAIT, VALID and HALT, one-hot or encoded.
- IDLE->REQ unconditionally.
- REQ: imem_req=1 for exactly one cycle, imem_addr=PC, then ->WAIT.
- WAIT: on imem_rvalid, instr<=imem_rdata, ->VALID; otherwise stay, with no timeout.
- VALID: instr_valid=1 and instr stable until instr_ready.
- VALID & instr_ready: PC<=next PC, ->REQ.
REQ-017 imem_rvalid SHALL be ignored in IDLE, REQ, VALID and HALT; the memory latency is at least 1 cycle.
REQ-018 Next PC SHALL be PCTarget when PCSrc=1, else PCPlus4; PCSrc and PCTarget are sampled only in the VALID & instr_ready cycle.
REQ-019 PC arithmetic SHALL be 32-bit unsigned with wrap-around: 32'hFFFF_FFFC+4 = 32'h0000_0000.
REQ-020 Minimum throughput SHALL be one instruction per 3 cycles (REQ, WAIT with rvalid, VALID with ready).
REQ-021 imem_addr SHALL equal PC in every state; imem_req SHALL be 0 outside REQ.
REQ-022 instr_valid SHALL be 0 outside VALID; instr SHALL hold its last captured value outside VALID.

Reset
REQ-023 On reset_n=0, independent of clk, the module SHALL immediately set: state IDLE, PC=RESET_PC, instr=32'h0000_0013 (NOP), instr_valid=0, imem_req=0, misalign=0.
REQ-024 On reset mid-operation, an outstanding read SHALL be abandoned; an imem_rvalid arriving after reset release SHALL be ignored under REQ-017.
REQ-025 The first request after release SHALL occur in the second rising edge's cycle (IDLE then REQ).

Configuration
REQ-026 The macro FETCH_MISALIGN_CHK_EN SHALL select misaligned-target handling.
- Defined: a taken target with PCTarget[1:0]!=0 leaves PC unchanged, sets misalign=1 and enters HALT. HALT has no requests and instr_valid=0, and exits only by reset.
- Undefined: the PC loads {PCTarget[31:2],2'b00}, and misalign is tied 0.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Sequential fetch: reset, RESET_PC=0, 1-cycle memory, ready=1 always -> imem_addr 0,4,8,C on successive REQ cycles; instr_valid every 3rd cycle.
- Branch taken: VALID at PC=0x10 with PCSrc=1, PCTarget=0x40, ready=1 -> next imem_addr=0x40; PCSrc=1 outside the accept cycle has no effect.
- Backpressure: ready=0 for 5 cycles in VALID -> instr, PC and instr_valid stable, and no imem_req.
- Wrap: PC=0xFFFF_FFFC accepted with PCSrc=0 -> next imem_addr=0x0000_0000.
- Async reset in WAIT, then rvalid=1 with rdata=0xDEADBEEF one cycle after release -> instr stays 0x0000_0013, and the first request goes to RESET_PC.
- Misaligned target 0x42 -> with the macro, misalign=1, HALT and no requests; without it, the next imem_addr=0x40.
